mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: address width of both requesters and the memory port.
REQ-002 Parameter DATA_W, default 16: data word width.
REQ-003 Parameter STARVE_MAX, default 2: maximum consecutive data grants while a fetch is pending.
REQ-004 clock  in  1  single clock; all state SHALL change on its rising edge; reset is asynchronous and active-high.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fetch_req  in  1  instruction fetch request, held until fetch_ack.
REQ-007 fetch_addr  in  ADDR_W  fetch address, stable while fetch_req is high.
REQ-008 fetch_ack  out  1  one-cycle pulse: fetch_data valid.
REQ-009 fetch_data  out  DATA_W  fetched word.
REQ-010 data_req  in  1  load/store request, held until data_ack.
REQ-011 data_we  in  1  1 = store, 0 = load.
REQ-012 data_addr  in  ADDR_W  load/store address.
REQ-013 data_wdata  in  DATA_W  store data.
REQ-014 data_ack  out  1  one-cycle pulse: access complete; data_rdata valid for loads.
REQ-015 data_rdata  out  DATA_W  loaded word.
REQ-016 mem_enable, mem_write_enable  out  1 each  memory port controls.
REQ-017 mem_address  out  ADDR_W; mem_write_data  out  DATA_W  memory port address and store data.
REQ-018 mem_read_data  in  DATA_W  combinational read data from the memory.
REQ-019 busy  out  1  high in every state other than IDLE.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS and RESP; every output SHALL be registered or decoded from state only.
REQ-021 In IDLE, when any request is sampled high at an edge, the FSM SHALL latch the winner's address, write-enable and write data and enter ACCESS.
REQ-022 Arbitration SHALL grant data when only data_req is high, and fetch when only fetch_req is high.
REQ-023 When both requests are high, the arbiter SHALL grant data unless starve_cnt equals STARVE_MAX, in which case it SHALL grant fetch.
REQ-024 starve_cnt SHALL increment on a data grant made while fetch_req is high, clear on any fetch grant, and saturate at STARVE_MAX.
REQ-025 In ACCESS, for exactly one cycle, mem_enable=1, mem_address and mem_write_data SHALL be the latched values, and mem_write_enable SHALL equal the latched we (always 0 for fetch).
REQ-026 At the edge ending ACCESS, the arbiter SHALL capture mem_read_data into fetch_data or data_rdata (loads only) and enter RESP.
REQ-027 A store SHALL leave data_rdata unchanged.
REQ-028 In RESP, the arbiter SHALL pulse the granted requester's ack for one cycle, then return to IDLE.
REQ-029 Requests SHALL NOT be sampled during RESP.
REQ-030 Latency SHALL be 2 cycles from the request-sampling edge to the ack cycle; throughput SHALL be one access per 3 cycles.
REQ-031 In ACCESS, mem_enable SHALL be 1; in IDLE and RESP, all mem_* outputs SHALL be 0.
REQ-032 A requester that drops its req before its ack SHALL still receive the ack; the access is not cancellable.
REQ-033 Address wrap-around SHALL NOT be handled by the arbiter: addresses pass through unmodified.

Reset
REQ-034 While reset is high, state SHALL be IDLE and starve_cnt, fetch_ack, data_ack, busy and all mem_* outputs SHALL be 0.
REQ-035 While reset is high, fetch_data and data_rdata SHALL be 0.
REQ-036 Reset asserted during ACCESS SHALL drop mem_write_enable immediately, so no store commits, and no ack SHALL be issued for the aborted access.
REQ-037 After reset deasserts, the first edge with a request SHALL follow REQ-021.

Structure
REQ-038 The ADDR_W/DATA_W defaults and the state encoding SHALL live in the shared processor package.
REQ-039 No sub-module SHALL be used: the FSM, latches and starvation counter live in one module, and the memory is instantiated beside it at processor top level.

Verification
REQ-040 Scenario: memory word 0x0003=0x1234; fetch_req with fetch_addr=0x0003 -> fetch_ack 2 cycles later with fetch_data=0x1234; mem_write_enable never high.
REQ-041 Scenario: store to 0x0010 with data 0xBEEF, then load 0x0010 -> data_ack for each; the load returns 0xBEEF; data_rdata is unchanged after the store.
REQ-042 Scenario: fetch_req and data_req held high continuously -> grant order data, data, fetch, data, data, fetch; starve_cnt saturates at 2.
REQ-043 Scenario: reset pulsed during the ACCESS of a store of 0xAAAA to 0x0005 -> memory still holds its old value, no data_ack, busy=0.
REQ-044 Scenario: fetch_req dropped during ACCESS -> fetch_ack still pulses once; a new data_req raised during RESP is sampled only after the return to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-cycle memory port between instruction fetch and load/store,
// with a bounded starvation guard that lets a waiting fetch through.
//
// state     | meaning
// ST_IDLE   | sampling requests, memory port quiet
// ST_ACCESS | one-cycle memory access with the latched address/data
// ST_RESP   | one-cycle ack pulse to the granted requester
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic          grant_is_data;
  logic          pick_data;
  logic          starve_full;

  assign starve_full = (starve_cnt == SW'(STARVE_MAX));

  // Data wins by default; fetch wins once it has been passed over STARVE_MAX times.
  always_comb begin
    pick_data = 1'b0;
    if (data_req && !(fetch_req && starve_full))
      pick_data = 1'b1;
  end

  // The mem_* registers double as the latched request, so ACCESS drives them directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      starve_cnt       <= '0;
      grant_is_data    <= 1'b0;
      fetch_ack        <= 1'b0;
      data_ack         <= 1'b0;
      fetch_data       <= '0;
      data_rdata       <= '0;
      mem_enable       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      busy             <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_req || data_req) begin
            grant_is_data <= pick_data;
            mem_enable    <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_ACCESS;
            if (pick_data) begin
              mem_address      <= data_addr;
              mem_write_enable <= data_we;
              mem_write_data   <= data_wdata;
              if (fetch_req && !starve_full)
                starve_cnt <= starve_cnt + 1'b1;
            end else begin
              mem_address      <= fetch_addr;
              mem_write_enable <= 1'b0;
              mem_write_data   <= '0;
              starve_cnt       <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (grant_is_data) begin
            if (!mem_write_enable)
              data_rdata <= mem_read_data;
            data_ack <= 1'b1;
          end else begin
            fetch_data <= mem_read_data;
            fetch_ack  <= 1'b1;
          end
          mem_enable       <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_address      <= '0;
          mem_write_data   <= '0;
          state            <= ST_RESP;
        end
        ST_RESP: begin
          fetch_ack <= 1'b0;
          data_ack  <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus directed scenarios
// (fetch, store/load, starvation order, reset mid-store, dropped request).
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SM = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_req, data_req, data_we;
  logic [AW-1:0] fetch_addr, data_addr;
  logic [DW-1:0] data_wdata;
  logic          fetch_ack, data_ack;
  logic [DW-1:0] fetch_data, data_rdata;
  logic          mem_enable, mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Memory beside the arbiter: combinational read, write at the edge ending ACCESS.
  logic [DW-1:0] mem [0:65535];
  assign mem_read_data = mem[mem_address];
  always @(posedge clock)
    if (mem_enable && mem_write_enable) mem[mem_address] <= mem_write_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each grant is a 3-cycle transaction (access cycle, ack cycle, back to idle).
  int            cyc_in_txn = 0;
  bit            m_data = 0;
  bit            m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            starve = 0;
  logic [DW-1:0] m_fd = '0;
  logic [DW-1:0] m_rd = '0;
  bit            grants[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_in_txn = 0; starve = 0; m_fd = '0; m_rd = '0;
      m_data = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    end else if (cyc_in_txn == 0) begin
      if (fetch_req || data_req) begin
        m_data = data_req && !(fetch_req && starve == SM);
        if (m_data) begin
          m_addr = data_addr; m_we = data_we; m_wdata = data_wdata;
          if (fetch_req && starve < SM) starve++;
        end else begin
          m_addr = fetch_addr; m_we = 0; m_wdata = '0; starve = 0;
        end
        grants.push_back(m_data);
        cyc_in_txn = 1;
      end
    end else if (cyc_in_txn == 1) begin
      if (m_data) begin
        if (!m_we) m_rd = mem[m_addr];
      end else m_fd = mem[m_addr];
      cyc_in_txn = 2;
    end else begin
      cyc_in_txn = 0;
    end
  end

  int n_fack = 0, n_dack = 0, n_we = 0;

  always @(negedge clock) begin
    chk("busy", busy, 32'(cyc_in_txn != 0));
    chk("mem_enable", mem_enable, 32'(cyc_in_txn == 1));
    chk("mem_write_enable", mem_write_enable, 32'(cyc_in_txn == 1 && m_we));
    chk("mem_address", mem_address, (cyc_in_txn == 1) ? 32'(m_addr) : 32'd0);
    chk("mem_write_data", mem_write_data, (cyc_in_txn == 1) ? 32'(m_wdata) : 32'd0);
    chk("fetch_ack", fetch_ack, 32'(cyc_in_txn == 2 && !m_data));
    chk("data_ack", data_ack, 32'(cyc_in_txn == 2 && m_data));
    chk("fetch_data", fetch_data, 32'(m_fd));
    chk("data_rdata", data_rdata, 32'(m_rd));
    if (fetch_ack === 1'b1) n_fack++;
    if (data_ack === 1'b1) n_dack++;
    if (mem_write_enable === 1'b1) n_we++;
  end

  task automatic wait_ack(input bit want_data, output int lat);
    bit seen = 0;
    lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      lat++;
      if ((want_data ? data_ack : fetch_ack) === 1'b1) seen = 1;
    end
    if (!seen) chk(want_data ? "timeout data_ack" : "timeout fetch_ack", 0, 1);
  endtask

  task automatic wait_any(output bit was_data);
    bit seen = 0;
    was_data = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (data_ack === 1'b1) begin seen = 1; was_data = 1; end
      else if (fetch_ack === 1'b1) seen = 1;
    end
    if (!seen) chk("timeout any ack", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, base, we0, d0, f0;
    bit  wd;
    bit  order[6];
    bit  exp_order[6];
    exp_order = '{1, 1, 0, 1, 1, 0};

    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem[16'h0003] = 16'h1234;
    mem[16'h0005] = 16'h5555;
    fetch_req = 0; data_req = 0; data_we = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0;
    reset = 1;
    repeat (2) @(negedge clock);
    chk("reset busy", busy, 0);
    chk("reset fetch_data", fetch_data, 0);
    reset = 0;
    @(negedge clock);

    // Fetch of a preloaded word
    we0 = n_we;
    fetch_req = 1; fetch_addr = 16'h0003;
    wait_ack(0, lat);
    fetch_req = 0;
    chk("s1 latency", lat, 2);
    chk("s1 fetch_data", fetch_data, 16'h1234);
    chk("s1 no write", n_we - we0, 0);
    @(negedge clock);

    // Store then load of the same word
    data_req = 1; data_we = 1; data_addr = 16'h0010; data_wdata = 16'hBEEF;
    wait_ack(1, lat);
    data_req = 0;
    chk("s2 store keeps rdata", data_rdata, 16'h0000);
    chk("s2 mem written", mem[16'h0010], 16'hBEEF);
    @(negedge clock);
    data_req = 1; data_we = 0;
    wait_ack(1, lat);
    data_req = 0;
    chk("s2 load rdata", data_rdata, 16'hBEEF);
    @(negedge clock);

    // Both requesters held high: starvation guard lets every third grant go to fetch
    base = grants.size();
    fetch_req = 1; fetch_addr = 16'h0003;
    data_req = 1; data_we = 0; data_addr = 16'h0010;
    for (int i = 0; i < 6; i++) begin
      wait_any(wd);
      order[i] = wd;
    end
    fetch_req = 0; data_req = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("s3 ack order %0d", i), 32'(order[i]), 32'(exp_order[i]));
      chk($sformatf("s3 model order %0d", i), 32'(grants[base + i]), 32'(exp_order[i]));
    end
    @(negedge clock);

    // Reset during the access of a store: nothing commits, no ack
    d0 = n_dack;
    data_req = 1; data_we = 1; data_addr = 16'h0005; data_wdata = 16'hAAAA;
    @(posedge clock);
    #2;
    reset = 1; data_req = 0; data_we = 0;
    @(negedge clock);
    chk("s4 we dropped", mem_write_enable, 0);
    @(negedge clock);
    reset = 0;
    repeat (4) @(negedge clock);
    chk("s4 mem unchanged", mem[16'h0005], 16'h5555);
    chk("s4 no data_ack", n_dack - d0, 0);
    chk("s4 busy", busy, 0);

    // Fetch dropped mid-access still acks; data raised in RESP waits for IDLE
    fetch_req = 1; fetch_addr = 16'h0003;
    @(negedge clock);
    f0 = n_fack;
    fetch_req = 0;
    @(negedge clock);
    chk("s5 fetch_ack despite drop", fetch_ack, 1);
    data_req = 1; data_we = 0; data_addr = 16'h0010;
    wait_ack(1, lat);
    data_req = 0;
    chk("s5 data latency from RESP", lat, 3);
    chk("s5 single fetch_ack", n_fack - f0, 1);
    chk("s5 load rdata", data_rdata, 16'hBEEF);
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
